// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
//   One sram-like bus channel: request fields flow master -> slave,
//   rdata and the addr_ok/data_ok handshakes flow slave -> master.
//   Ports (signals):
//     req, wr        request and write flag
//     size[1:0]      0=byte, 1=half, 2=word
//     addr, wdata    request address and write data
//     rdata          read data returned by the slave
//     addr_ok        request accepted by the slave
//     data_ok        data phase complete (rdata valid on reads)
//   Modports: master drives the request side, slave drives the response side.
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              addr_ok;
  logic              data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one sram-like slave (normally the AXI bridge) between the
//   instruction fetch port and the data memory port. One transaction is in
//   flight at a time; the grant is locked from the first slave req until
//   addr_ok, and addr_ok/data_ok/rdata are routed back to the owner.
//   Zero added latency: in IDLE the slave request follows the masters
//   combinationally, and all master handshakes are combinational.
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     inst_bus   instruction master channel (slave modport)
//     data_bus   data master channel (slave modport)
//     sram_bus   shared slave channel (master modport)
//     busy       high while a transaction is in ADDR or DATA
//     owner      grant, 0 = inst, 1 = data
//
//   Optional feature macro: SRAM_ARB_ROUND_ROBIN_EN
//     undefined : fixed priority, data wins every tie
//     defined   : ties go to the master not granted last (data first)
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | no transaction; grant computed live from both requests
//   ADDR  | request issued, waiting for addr_ok; grant frozen
//   DATA  | address accepted, waiting for data_ok; sram_req low
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  inst_bus,
  sram_like_arbiter_if.slave  data_bus,
  sram_like_arbiter_if.master sram_bus,
  output logic                busy,
  output logic                owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  logic              any_req;
  logic              tie_winner;
  logic              idle_grant;
  logic              sel;
  logic              sram_req_w;
  logic              addr_fire;
  logic              data_fire;
  logic              mux_wr;
  logic [1:0]        mux_size;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  // Grant selection: live in IDLE, frozen to the latched owner otherwise.
  always_comb begin
    any_req = inst_bus.req | data_bus.req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    tie_winner = ~last_q;
`else
    tie_winner = 1'b1;
`endif
    idle_grant = (inst_bus.req & data_bus.req) ? tie_winner : data_bus.req;
    sel        = (state_q == ST_IDLE) ? idle_grant : owner_q;
  end

  always_comb begin
    sram_req_w = 1'b0;
    mux_wr     = 1'b0;
    mux_size   = '0;
    mux_addr   = '0;
    mux_wdata  = '0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: sram_req_w = any_req;
        ST_ADDR: sram_req_w = sel ? data_bus.req : inst_bus.req;
        default: sram_req_w = 1'b0;
      endcase
      if (sel) begin
        mux_wr    = data_bus.wr;
        mux_size  = data_bus.size;
        mux_addr  = data_bus.addr;
        mux_wdata = data_bus.wdata;
      end else begin
        mux_wr    = inst_bus.wr;
        mux_size  = inst_bus.size;
        mux_addr  = inst_bus.addr;
        mux_wdata = inst_bus.wdata;
      end
    end
    // addr_ok only counts while we are actually requesting; data_ok only
    // counts in DATA, so stray slave pulses never reach a master.
    addr_fire = sram_req_w & sram_bus.addr_ok;
    data_fire = ~rst & (state_q == ST_DATA) & sram_bus.data_ok;
  end

  assign sram_bus.req   = sram_req_w;
  assign sram_bus.wr    = mux_wr;
  assign sram_bus.size  = mux_size;
  assign sram_bus.addr  = mux_addr;
  assign sram_bus.wdata = mux_wdata;

  assign inst_bus.addr_ok = addr_fire & ~sel;
  assign data_bus.addr_ok = addr_fire & sel;
  assign inst_bus.data_ok = data_fire & ~owner_q;
  assign data_bus.data_ok = data_fire & owner_q;

  // rdata is shared; only the owner's data_ok qualifies it.
  assign inst_bus.rdata = sram_bus.rdata;
  assign data_bus.rdata = sram_bus.rdata;

  assign busy  = ~rst & (state_q != ST_IDLE);
  assign owner = ~rst & sel;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    last_d  = last_q;
    if (addr_fire) last_d = sel;
`endif
    case (state_q)
      ST_IDLE: begin
        if (addr_fire) begin
          state_d = ST_DATA;
          owner_d = sel;
        end else if (any_req) begin
          state_d = ST_ADDR;
          owner_d = sel;
        end
      end
      ST_ADDR: if (addr_fire) state_d = ST_DATA;
      ST_DATA: if (data_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_sram_like_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic busy, owner;

  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) inst_if ();
  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) data_if ();
  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sram_if ();

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .inst_bus (inst_if),
    .data_bus (data_if),
    .sram_bus (sram_if),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {sram_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, busy, owner}
  function automatic logic [6:0] ctl_vec();
    return {sram_if.req, inst_if.addr_ok, inst_if.data_ok,
            data_if.addr_ok, data_if.data_ok, busy, owner};
  endfunction

  task automatic idle_inputs();
    inst_if.req = 0; inst_if.wr = 0; inst_if.size = 0; inst_if.addr = 0; inst_if.wdata = 0;
    data_if.req = 0; data_if.wr = 0; data_if.size = 0; data_if.addr = 0; data_if.wdata = 0;
    sram_if.rdata = 0; sram_if.addr_ok = 0; sram_if.data_ok = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] c;
    rst = 1;
    idle_inputs();
    inst_if.req = 1; inst_if.addr = 32'h1234_5678; data_if.req = 1; data_if.wdata = 32'hFFFF_0000;
    sram_if.addr_ok = 1; sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL reset_ctl: got %b expected %b", c, 7'b0000000); end
    n_cmp++;
    if ({sram_if.addr, sram_if.wdata} !== 64'h0) begin
      n_err++; $display("FAIL reset_mux: got %h/%h expected 0/0", sram_if.addr, sram_if.wdata);
    end
    next_cycle();
    @(negedge clk);
    next_cycle();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL reset_release_ctl: got %b expected %b", c, 7'b0000000); end
  endtask

  task automatic test_inst_read();
    logic [6:0] c;
    next_cycle();
    inst_if.req = 1; inst_if.wr = 0; inst_if.size = 2; inst_if.addr = 32'hBFC0_0000;
    sram_if.addr_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1100000) begin n_err++; $display("FAIL inst_read_c0_ctl: got %b expected %b", c, 7'b1100000); end
    n_cmp++;
    if (sram_if.addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL inst_read_addr: got %h expected bfc00000", sram_if.addr); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000010) begin n_err++; $display("FAIL inst_read_c1_ctl: got %b expected %b", c, 7'b0000010); end
    next_cycle();
    sram_if.data_ok = 1; sram_if.rdata = 32'h3C1D_0000;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0010010) begin n_err++; $display("FAIL inst_read_c2_ctl: got %b expected %b", c, 7'b0010010); end
    n_cmp++;
    if (inst_if.rdata !== 32'h3C1D_0000) begin n_err++; $display("FAIL inst_read_rdata: got %h expected 3c1d0000", inst_if.rdata); end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL inst_read_end_ctl: got %b expected %b", c, 7'b0000000); end
  endtask

  task automatic test_tie();
    logic [6:0] c;
    next_cycle();
    inst_if.req = 1; inst_if.wr = 0; inst_if.size = 2; inst_if.addr = 32'hBFC0_0000;
    data_if.req = 1; data_if.wr = 1; data_if.size = 2; data_if.addr = 32'h8000_1000; data_if.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1000001) begin n_err++; $display("FAIL tie_c0_ctl: got %b expected %b", c, 7'b1000001); end
    n_cmp++;
    if ({sram_if.wr, sram_if.size, sram_if.addr, sram_if.wdata} !== {1'b1, 2'd2, 32'h8000_1000, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL tie_c0_mux: got wr=%b size=%0d addr=%h wdata=%h expected 1/2/80001000/deadbeef",
                        sram_if.wr, sram_if.size, sram_if.addr, sram_if.wdata);
    end
    next_cycle();
    sram_if.addr_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1001011) begin n_err++; $display("FAIL tie_c1_ctl: got %b expected %b", c, 7'b1001011); end
    next_cycle();
    data_if.req = 0; sram_if.addr_ok = 0; sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000111) begin n_err++; $display("FAIL tie_c2_ctl: got %b expected %b", c, 7'b0000111); end
    n_cmp++;
    if (inst_if.addr !== 32'hBFC0_0000) begin n_err++; $display("FAIL tie_inst_hold: got %h expected bfc00000", inst_if.addr); end
    next_cycle();
    sram_if.data_ok = 0; sram_if.addr_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1100000) begin n_err++; $display("FAIL tie_c3_ctl: got %b expected %b", c, 7'b1100000); end
    n_cmp++;
    if ({sram_if.wr, sram_if.addr} !== {1'b0, 32'hBFC0_0000}) begin
      n_err++; $display("FAIL tie_c3_mux: got wr=%b addr=%h expected 0/bfc00000", sram_if.wr, sram_if.addr);
    end
    next_cycle();
    inst_if.req = 0; sram_if.addr_ok = 0; sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0010010) begin n_err++; $display("FAIL tie_c4_ctl: got %b expected %b", c, 7'b0010010); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_grant_lock();
    logic [6:0] c;
    next_cycle();
    inst_if.req = 1; inst_if.size = 2; inst_if.addr = 32'h1FC0_0040;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1000000) begin n_err++; $display("FAIL lock_c0_ctl: got %b expected %b", c, 7'b1000000); end
    for (int k = 1; k <= 2; k++) begin
      next_cycle();
      data_if.req = 1; data_if.wr = 1; data_if.size = 2; data_if.addr = 32'h8000_2000; data_if.wdata = 32'h5A5A_A5A5;
      @(negedge clk);
      c = ctl_vec();
      n_cmp++;
      if (c !== 7'b1000010) begin n_err++; $display("FAIL lock_c%0d_ctl: got %b expected %b", k, c, 7'b1000010); end
      n_cmp++;
      if (sram_if.addr !== 32'h1FC0_0040) begin n_err++; $display("FAIL lock_c%0d_addr: got %h expected 1fc00040", k, sram_if.addr); end
    end
    next_cycle();
    sram_if.addr_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1100010) begin n_err++; $display("FAIL lock_c3_ctl: got %b expected %b", c, 7'b1100010); end
    next_cycle();
    inst_if.req = 0; sram_if.addr_ok = 0; sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0010010) begin n_err++; $display("FAIL lock_c4_ctl: got %b expected %b", c, 7'b0010010); end
    next_cycle();
    sram_if.data_ok = 0; sram_if.addr_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1001001) begin n_err++; $display("FAIL lock_c5_ctl: got %b expected %b", c, 7'b1001001); end
    n_cmp++;
    if (sram_if.addr !== 32'h8000_2000) begin n_err++; $display("FAIL lock_c5_addr: got %h expected 80002000", sram_if.addr); end
    next_cycle();
    data_if.req = 0; sram_if.addr_ok = 0; sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000111) begin n_err++; $display("FAIL lock_c6_ctl: got %b expected %b", c, 7'b0000111); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_stray_and_reset();
    logic [6:0] c;
    next_cycle();
    idle_inputs();
    sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL stray_dok_ctl: got %b expected %b", c, 7'b0000000); end
    next_cycle();
    sram_if.data_ok = 0; sram_if.addr_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL stray_aok_ctl: got %b expected %b", c, 7'b0000000); end
    next_cycle();
    inst_if.req = 1; inst_if.addr = 32'hBFC0_0100;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b1100000) begin n_err++; $display("FAIL midrst_issue_ctl: got %b expected %b", c, 7'b1100000); end
    next_cycle();
    idle_inputs();
    rst = 1; sram_if.data_ok = 1;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL midrst_hold_ctl: got %b expected %b", c, 7'b0000000); end
    next_cycle();
    rst = 0;
    @(negedge clk);
    c = ctl_vec();
    n_cmp++;
    if (c !== 7'b0000000) begin n_err++; $display("FAIL midrst_late_dok_ctl: got %b expected %b", c, 7'b0000000); end
    next_cycle();
    idle_inputs();
  endtask

  // Both masters request continuously; slave answers as fast as allowed.
  task automatic test_stream();
    logic [6:0] c, e;
    bit exp_own;
    next_cycle();
    rst = 1; idle_inputs();
    next_cycle();
    rst = 0;
    for (int t = 0; t < 4; t++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_own = (t % 2 == 0);
`else
      exp_own = 1'b1;
`endif
      next_cycle();
      inst_if.req = 1; inst_if.size = 2; inst_if.addr = 32'hBFC0_0000 + 32'(4 * t);
      data_if.req = 1; data_if.size = 2; data_if.addr = 32'h8000_0000 + 32'(4 * t);
      sram_if.addr_ok = 1; sram_if.data_ok = 0;
      @(negedge clk);
      c = ctl_vec();
      e = {1'b1, ~exp_own, 1'b0, exp_own, 1'b0, 1'b0, exp_own};
      n_cmp++;
      if (c !== e) begin n_err++; $display("FAIL stream_t%0d_addr_ctl: got %b expected %b", t, c, e); end
      next_cycle();
      sram_if.addr_ok = 0; sram_if.data_ok = 1; sram_if.rdata = $urandom;
      @(negedge clk);
      c = ctl_vec();
      e = {1'b0, 1'b0, ~exp_own, 1'b0, exp_own, 1'b1, exp_own};
      n_cmp++;
      if (c !== e) begin n_err++; $display("FAIL stream_t%0d_data_ctl: got %b expected %b", t, c, e); end
    end
    next_cycle();
    idle_inputs();
  endtask

  // Arbitration rule from the bench's point of view: who wins a request cycle.
  function automatic int pick(bit r0, bit r1, int last_g);
    if (r0 && r1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      return (last_g == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic test_random();
    bit          m_req[2];
    bit          m_wr[2];
    logic [1:0]  m_size[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    bit          acc[2];
    int          lock, outst, last_g, pend, who;
    bit          s_aok, s_dok, rst_v, e_sreq, e_busy;
    bit [1:0]    e_aok, e_dok;
    logic [31:0] s_rdata;
    logic [5:0]  c6, e6;
    next_cycle();
    rst = 1; idle_inputs();
    next_cycle();
    rst = 0;
    lock = -1; outst = -1; last_g = 0; pend = 0;
    for (int m = 0; m < 2; m++) begin m_req[m] = 0; acc[m] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      for (int m = 0; m < 2; m++) begin
        if (m_req[m] && acc[m]) m_req[m] = 0;
        if (!m_req[m] && $urandom_range(0, 99) < 35) begin
          m_req[m] = 1; m_wr[m] = 1'($urandom_range(0, 1)); m_size[m] = 2'($urandom_range(0, 2));
          m_addr[m] = $urandom; m_wdata[m] = $urandom;
        end
        acc[m] = 0;
      end
      rst_v = ($urandom_range(0, 149) == 0);
      s_aok = ($urandom_range(0, 99) < 40);
      s_dok = 0;
      s_rdata = $urandom;
      if (pend == 1) begin s_dok = 1; pend = 0; end
      else if (pend > 1) pend--;
      else s_dok = ($urandom_range(0, 99) < 8);
      rst = rst_v;
      inst_if.req = m_req[0]; inst_if.wr = m_wr[0]; inst_if.size = m_size[0]; inst_if.addr = m_addr[0]; inst_if.wdata = m_wdata[0];
      data_if.req = m_req[1]; data_if.wr = m_wr[1]; data_if.size = m_size[1]; data_if.addr = m_addr[1]; data_if.wdata = m_wdata[1];
      sram_if.addr_ok = s_aok; sram_if.data_ok = s_dok; sram_if.rdata = s_rdata;
      @(negedge clk);
      e_sreq = 0; e_busy = 0; e_aok = 0; e_dok = 0; who = 0;
      if (rst_v) begin
        who = 0;
      end else if (outst >= 0) begin
        who = outst; e_busy = 1; e_dok[outst] = s_dok;
      end else begin
        who    = (lock >= 0) ? lock : pick(m_req[0], m_req[1], last_g);
        e_busy = (lock >= 0);
        e_sreq = (lock >= 0) ? m_req[lock] : (m_req[0] | m_req[1]);
        e_aok[who] = e_sreq & s_aok;
      end
      c6 = ctl_vec() >> 1;
      e6 = {e_sreq, e_aok[0], e_dok[0], e_aok[1], e_dok[1], e_busy};
      n_cmp++;
      if (c6 !== e6) begin n_err++; $display("FAIL rand_ctl cycle %0d: got %b expected %b", cyc, c6, e6); end
      if (rst_v || e_sreq || e_busy) begin
        n_cmp++;
        if (owner !== (rst_v ? 1'b0 : 1'(who))) begin
          n_err++; $display("FAIL rand_owner cycle %0d: got %b expected %0d", cyc, owner, rst_v ? 0 : who);
        end
      end
      if (rst_v) begin
        n_cmp++;
        if ({sram_if.wr, sram_if.size, sram_if.addr, sram_if.wdata} !== 67'h0) begin
          n_err++; $display("FAIL rand_rst_mux cycle %0d: got addr=%h wdata=%h expected 0", cyc, sram_if.addr, sram_if.wdata);
        end
      end else if (e_sreq) begin
        n_cmp++;
        if ({sram_if.wr, sram_if.size, sram_if.addr, sram_if.wdata} !== {m_wr[who], m_size[who], m_addr[who], m_wdata[who]}) begin
          n_err++; $display("FAIL rand_mux cycle %0d: got %b/%0d/%h/%h expected %b/%0d/%h/%h", cyc,
                            sram_if.wr, sram_if.size, sram_if.addr, sram_if.wdata,
                            m_wr[who], m_size[who], m_addr[who], m_wdata[who]);
        end
      end
      if (e_dok != 0) begin
        n_cmp++;
        if ((e_dok[0] ? inst_if.rdata : data_if.rdata) !== s_rdata) begin
          n_err++; $display("FAIL rand_rdata cycle %0d: got %h expected %h", cyc,
                            e_dok[0] ? inst_if.rdata : data_if.rdata, s_rdata);
        end
      end
      if (rst_v) begin
        lock = -1; outst = -1; last_g = 0;
      end else if (outst >= 0) begin
        if (s_dok) outst = -1;
      end else if (e_sreq && s_aok) begin
        outst = who; lock = -1; last_g = who; acc[who] = 1;
        pend = $urandom_range(1, 3);
      end else if (e_sreq) begin
        lock = who;
      end
    end
    next_cycle();
    rst = 0; idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_inst_read();
    test_tie();
    test_grant_lock();
    test_stray_and_reset();
    test_stream();
    test_random();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master to one-slave arbiter for the CPU's sram-like bus: the instruction fetch port and the data memory port share a single sram-like slave, normally the AXI bridge. It serialises transactions with at most one outstanding request, locks the grant from the first slave `req` until `addr_ok`, and routes `addr_ok`, `data_ok` and `rdata` back to the owning master. It sits between the fetch/memory-stage ports and the bridge.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_req`, `inst_wr`  in  1  instruction master request and write flag.
- `inst_size`  in  2  instruction master size (0=byte, 1=half, 2=word).
- `inst_addr`  in  ADDR_W  instruction master address.
- `inst_wdata`  in  DATA_W  instruction master write data.
- `inst_rdata`  out  DATA_W  slave read data, passed through unregistered.
- `inst_addr_ok`, `inst_data_ok`  out  1  handshakes returned to the instruction master.
- `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `data_rdata`, `data_addr_ok`, `data_data_ok`: same set for the data master.
- `sram_req`, `sram_wr`  out  1  slave request and write flag.
- `sram_size`  out  2  slave size.
- `sram_addr`  out  ADDR_W  slave address.
- `sram_wdata`  out  DATA_W  slave write data.
- `sram_rdata`  in  DATA_W  slave read data.
- `sram_addr_ok`, `sram_data_ok`  in  1  slave handshakes.
- `busy`  out  1  high in ADDR or DATA.
- `owner`  out  1  grant: 0 = inst, 1 = data. Valid whenever `sram_req` or `busy` is high.

## Operation
- FSM states are IDLE, ADDR and DATA. Reset puts the FSM in IDLE.
- The slave mux (`sram_wr`, `sram_size`, `sram_addr`, `sram_wdata`) selects the granted master's signals.
- IDLE:
  - Grant is computed combinationally from this cycle's `inst_req` and `data_req`. `sram_req = inst_req | data_req`.
  - If `sram_addr_ok` is high in the same cycle: pulse the granted master's `addr_ok`, latch `owner`, go to DATA.
  - Otherwise, if any request is present: latch `owner`, go to ADDR.
- ADDR:
  - The grant is frozen and `sram_req` is driven from the latched owner's request.
  - The losing master's `addr_ok` stays 0.
  - On `sram_addr_ok`: pulse the owner's `addr_ok`, go to DATA.
- DATA:
  - `sram_req = 0`; both master `addr_ok` outputs are 0.
  - On `sram_data_ok`: pulse the owner's `data_ok`, go to IDLE.
- `inst_rdata` and `data_rdata` are both wired to `sram_rdata`. Only the owner's `data_ok` qualifies it.
- Masters hold `req`, `addr`, `wr`, `size` and `wdata` stable from `req` rise until their `addr_ok`. The arbiter does not register these fields.
- Boundary behaviour:
  - `sram_data_ok` in IDLE or ADDR (stray) is dropped: no master `data_ok`.
  - `sram_addr_ok` while `sram_req` is 0 is ignored.
  - A request that arrives during DATA waits in its master. It is arbitrated in IDLE at the earliest one cycle after `data_ok`. There are no back-to-back issues in the `data_ok` cycle.
  - Both requests in the same IDLE cycle are resolved per Configuration. The loser keeps `req` high and is served in the next transaction.
  - `rst` high mid-transaction: next cycle is IDLE. While `rst` is high, all master `addr_ok`/`data_ok` and `sram_req` are forced to 0.

## Timing
- Reset values:
  - `sram_req`, `inst_addr_ok`, `inst_data_ok`, `data_addr_ok`, `data_data_ok`, `busy`: 0.
  - `owner`: 0.
  - Slave mux fields: 0 while `rst` is high.
- Added latency is zero. `sram_req` follows a master `req` in the same cycle when in IDLE, and master `addr_ok`/`data_ok` are combinational from the slave handshakes.
- Minimum transaction is 2 cycles: `addr_ok` in cycle N, `data_ok` in cycle N+1 at the earliest. The next IDLE grant is in cycle N+2.
- At most one outstanding transaction at any time.

## Configuration
- `SRAM_ARB_ROUND_ROBIN_EN` undefined: fixed priority; data wins any tie.
- `SRAM_ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant register is added, updated on each accepted `addr_ok`. Reset value is "inst last", so data wins the first tie.
  - On a tie, the master not granted last wins.
  - Single requests are unaffected.

## Test plan
- Instruction read only: `inst_req=1`, `inst_addr=0xBFC00000`, slave `addr_ok` at cycle 0 and `data_ok` at cycle 2 with `rdata=0x3C1D0000`. Expect `inst_addr_ok` at 0, `inst_data_ok` and `inst_rdata=0x3C1D0000` at 2, `data_*_ok` never asserted.
- Tie, fixed priority: both `req` high in cycle 0 (data write to 0x80001000 with `wdata=0xDEADBEEF`, `size=2`). Expect the slave sees data first. Inst is issued in IDLE one cycle after the data `data_ok`; its `addr` holds 0xBFC00000 throughout.
- Grant lock: inst alone in cycle 0, slave withholds `addr_ok` for 3 cycles, `data_req` rises in cycle 1. Expect `owner` stays 0 and `sram_addr` stays the inst address until inst `addr_ok`.
- Stray and mid-op reset: `sram_data_ok` pulse in IDLE produces no master `data_ok`. `rst` asserted in DATA gives IDLE next cycle, `busy=0`, and a later slave `data_ok` is dropped.
- With `SRAM_ARB_ROUND_ROBIN_EN`: both masters requesting continuously. Expect grants alternate data, inst, data, inst across 4 transactions.
